// File: rtl/kyber_poly_inbuf.sv
// -----------------------------------------------------------------------------
// kyber_poly_inbuf
//
// Multi-channel coefficient input buffer placed in front of the kyber_pke_enc
// datapath. An indexed byte stream fills CHANNELS polynomial banks of
// 2^DEPTH entries each. Once every bank is closed, the buffer exposes a
// registered random-access read port until the consumer releases it.
//
// Parameters
//   DATA_W    coefficient / byte width of din and dout
//   DEPTH     log2 of entries per bank
//   CHANNELS  number of polynomial banks (1..4)
//
// Ports
//   clk, reset    single clock, synchronous active-high reset
//   set           run enable; 0 pauses loading
//   readin        upstream presents din/in_index this cycle
//   full_in       upstream marks the current bank finished
//   din, in_index write data and write address within the current bank
//   readin_ok     buffer accepts a write this cycle
//   cur_ch        bank currently being filled
//   fill_count    writes accepted into the current bank
//   rd_en, rd_ch, rd_index   read request, bank select, read address
//   dout, dout_valid         read data, valid one cycle after rd_en
//   done          all banks closed, buffer readable
//   release_req   consumer is finished; return to IDLE
//   state_dbg     current FSM state (0 IDLE, 1 LOAD, 2 READY)
//
// Handshake: a write is transferred on every rising edge where
// readin_ok=1 and readin=1 (valid/ready). readin_ok is registered, so it
// reflects set from the previous cycle; upstream must not assume a write
// was taken unless readin_ok was high in that same cycle.
// -----------------------------------------------------------------------------
module kyber_poly_inbuf #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              readin,
  input  logic              full_in,
  input  logic [DATA_W-1:0] din,
  input  logic [DEPTH-1:0]  in_index,
  output logic              readin_ok,
  output logic [1:0]        cur_ch,
  output logic [DEPTH:0]    fill_count,
  input  logic              rd_en,
  input  logic [1:0]        rd_ch,
  input  logic [DEPTH-1:0]  rd_index,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              done,
  input  logic              release_req,
  output logic [1:0]        state_dbg
);

  // Bank select bits used for memory addressing; banks are packed on a
  // power-of-two stride so the address is a plain concatenation.
  localparam int CH_BITS   = (CHANNELS > 2) ? 2 : 1;
  localparam int ADDR_W    = CH_BITS + DEPTH;
  localparam int MEM_WORDS = 1 << ADDR_W;

  localparam logic [1:0]     LAST_CH  = 2'(CHANNELS - 1);
  localparam logic [DEPTH:0] FULL_CNT = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] LAST_CNT = {1'b0, {DEPTH{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              readin_ok_q, readin_ok_d;
  logic [1:0]        cur_ch_q, cur_ch_d;
  logic [DEPTH:0]    fill_q, fill_d;
  logic              dout_valid_q, dout_valid_d;
  logic              done_q, done_d;
  logic              dout_zero_q, dout_zero_d;

  logic              wr_en;
  logic              rd_fire;
  logic              bank_close;
  logic              rd_ch_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] rd_word_q;

  assign rd_ch_ok = (rd_ch <= LAST_CH);
  assign wr_addr  = {cur_ch_q[CH_BITS-1:0], in_index};
  assign rd_addr  = {rd_ch[CH_BITS-1:0], rd_index};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    readin_ok_d  = readin_ok_q;
    cur_ch_d     = cur_ch_q;
    fill_d       = fill_q;
    dout_valid_d = 1'b0;
    done_d       = done_q;
    dout_zero_d  = dout_zero_q;
    wr_en        = 1'b0;
    rd_fire      = 1'b0;
    bank_close   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        readin_ok_d = 1'b0;
        done_d      = 1'b0;
        if (set) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        readin_ok_d = set;
        wr_en       = readin & readin_ok_q;
        if (wr_en && (fill_q != FULL_CNT)) begin
          fill_d = fill_q + 1'b1;
        end
        // full_in is only honoured while the buffer is accepting, so a
        // paused bank keeps its channel and count. The write that fills the
        // last entry closes the bank in the same edge it is stored.
        bank_close = readin_ok_q & (full_in | (wr_en & (fill_q == LAST_CNT)));
        if (bank_close) begin
          fill_d = '0;
          if (cur_ch_q != LAST_CH) begin
            cur_ch_d = cur_ch_q + 1'b1;
          end else begin
            readin_ok_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_READY;
          end
        end
      end

      ST_READY: begin
        readin_ok_d = 1'b0;
        if (rd_en) begin
          rd_fire      = 1'b1;
          dout_valid_d = 1'b1;
          dout_zero_d  = ~rd_ch_ok;
        end
        // A read issued together with release still completes: its
        // dout_valid pulse lands in the first IDLE cycle.
        if (release_req) begin
          state_d  = ST_IDLE;
          done_d   = 1'b0;
          cur_ch_d = '0;
          fill_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      readin_ok_q  <= 1'b0;
      cur_ch_q     <= '0;
      fill_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      dout_zero_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      readin_ok_q  <= readin_ok_d;
      cur_ch_q     <= cur_ch_d;
      fill_q       <= fill_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
      dout_zero_q  <= dout_zero_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank storage: one write port (LOAD) and one registered read port
  // (READY). Contents survive reset; only the control state is cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= din;
    end
    if (rd_fire && !reset) begin
      rd_word_q <= mem[rd_addr];
    end
  end

  // Out-of-range bank reads and the post-reset value are forced to zero by a
  // flag rather than by resetting the RAM output register.
  assign dout       = dout_zero_q ? '0 : rd_word_q;
  assign dout_valid = dout_valid_q;
  assign readin_ok  = readin_ok_q;
  assign cur_ch     = cur_ch_q;
  assign fill_count = fill_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_kyber_poly_inbuf.sv
module tb_kyber_poly_inbuf;

  localparam int DW   = 8;
  localparam int DP   = 8;
  localparam int CH   = 2;
  localparam int NENT = 256;

  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_READY = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          set = 1'b0;
  logic          readin = 1'b0;
  logic          full_in = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DP-1:0] in_index = '0;
  logic          readin_ok;
  logic [1:0]    cur_ch;
  logic [DP:0]   fill_count;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_ch = '0;
  logic [DP-1:0] rd_index = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          done;
  logic          release_req = 1'b0;
  logic [1:0]    state_dbg;

  kyber_poly_inbuf #(.DATA_W(DW), .DEPTH(DP), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .set(set), .readin(readin), .full_in(full_in),
    .din(din), .in_index(in_index), .readin_ok(readin_ok), .cur_ch(cur_ch),
    .fill_count(fill_count), .rd_en(rd_en), .rd_ch(rd_ch), .rd_index(rd_index),
    .dout(dout), .dout_valid(dout_valid), .done(done),
    .release_req(release_req), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
  endtask

  // ---------------------------------------------------------------- behavioural model
  logic [DW-1:0] exp_mem [CH][NENT];
  bit            known   [CH][NENT];
  int            m_state = S_IDLE;
  bit            m_rok = 0;
  int            m_ch = 0;
  int            m_fill = 0;
  bit            m_done = 0;
  bit            m_dvalid = 0;
  logic [DW-1:0] m_dout = '0;
  bit            m_dout_known = 1;
  bit            m_wrote;

  always @(posedge clk) begin
    if (reset) begin
      m_state = S_IDLE; m_rok = 0; m_ch = 0; m_fill = 0;
      m_done = 0; m_dvalid = 0; m_dout = '0; m_dout_known = 1;
    end else begin
      case (m_state)
        S_IDLE: begin
          m_dvalid = 0;
          if (set) m_state = S_LOAD;
        end
        S_LOAD: begin
          m_dvalid = 0;
          m_wrote = readin && m_rok;
          if (m_wrote) begin
            exp_mem[m_ch][in_index] = din;
            known[m_ch][in_index]   = 1;
            if (m_fill < NENT) m_fill++;
          end
          if (m_rok && (full_in || (m_wrote && m_fill == NENT))) begin
            m_fill = 0;
            if (m_ch < CH - 1) m_ch++;
            else begin
              m_state = S_READY;
              m_done  = 1;
            end
          end
          m_rok = (m_state == S_LOAD) ? set : 1'b0;
        end
        default: begin
          m_dvalid = rd_en;
          if (rd_en) begin
            if (rd_ch < CH) begin
              m_dout       = exp_mem[rd_ch][rd_index];
              m_dout_known = known[rd_ch][rd_index];
            end else begin
              m_dout       = '0;
              m_dout_known = 1;
            end
          end
          if (release_req) begin
            m_state = S_IDLE; m_done = 0; m_ch = 0;
          end
        end
      endcase
    end
  end

  // One compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("readin_ok",  32'(readin_ok),  32'(m_rok));
      check("cur_ch",     32'(cur_ch),     32'(m_ch));
      check("fill_count", 32'(fill_count), 32'(m_fill));
      check("done",       32'(done),       32'(m_done));
      check("dout_valid", 32'(dout_valid), 32'(m_dvalid));
      check("state",      32'(state_dbg),  32'(m_state));
      if (m_dout_known) check("dout", 32'(dout), 32'(m_dout));
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    readin = 0; full_in = 0; rd_en = 0; release_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    set = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic start_load();
    set = 1;
    tick();
    tick();
  endtask

  task automatic write(input int idx, input int data, input bit fin);
    readin = 1; in_index = DP'(idx); din = DW'(data); full_in = fin;
    tick();
    readin = 0; full_in = 0;
  endtask

  task automatic close_bank();
    full_in = 1;
    tick();
    full_in = 0;
  endtask

  task automatic read(input int c, input int idx, input string nm, input int exp_v);
    rd_en = 1; rd_ch = 2'(c); rd_index = DP'(idx);
    tick();
    rd_en = 0;
    check({nm, "_valid"}, 32'(dout_valid), 32'd1);
    check(nm, 32'(dout), 32'(exp_v));
  endtask

  task automatic do_release();
    set = 0; release_req = 1;
    tick();
    release_req = 0;
    tick();
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int cyc;

    // Reset state
    do_reset();
    check("rst_readin_ok", 32'(readin_ok), 0);
    check("rst_cur_ch", 32'(cur_ch), 0);
    check("rst_fill", 32'(fill_count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_state", 32'(state_dbg), S_IDLE);
    chk_en = 1;

    // Two full banks, auto-close on the last write of each
    start_load();
    check("load_rok", 32'(readin_ok), 1);
    for (int i = 0; i < NENT; i++) write(i, 255 - i, 0);
    check("auto_close_ch", 32'(cur_ch), 1);
    check("auto_close_fill", 32'(fill_count), 0);
    for (int i = 0; i < NENT; i++) write(i, i + 2, 0);
    check("full_rok", 32'(readin_ok), 0);
    check("full_done", 32'(done), 1);
    read(1, 37, "rd_1_37", 39);
    read(0, 37, "rd_0_37", 218);
    do_release();

    // Partial bank closed by full_in, then an empty bank
    start_load();
    for (int i = 0; i < 32; i++) write(i, 8'hC0 ^ i, 0);
    check("partial_fill", 32'(fill_count), 32);
    close_bank();
    check("partial_close_fill", 32'(fill_count), 0);
    check("partial_close_ch", 32'(cur_ch), 1);
    close_bank();
    check("empty_close_state", 32'(state_dbg), S_READY);
    read(0, 31, "rd_0_31", 8'hDF);
    read(0, 32, "rd_0_32_prior", 223);
    do_release();

    // Pause with set=0
    start_load();
    for (int i = 0; i < 10; i++) write(100 + i, 8'h30 + i, 0);
    set = 0;
    tick();
    check("pause_rok", 32'(readin_ok), 0);
    readin = 1; in_index = 8'd200; din = 8'hEE;
    for (int i = 0; i < 5; i++) tick();
    readin = 0;
    check("pause_fill", 32'(fill_count), 10);
    set = 1;
    tick();
    write(110, 8'h77, 0);
    check("resume_fill", 32'(fill_count), 11);
    close_bank();
    close_bank();
    read(0, 200, "rd_paused_idx", 55);
    read(0, 105, "rd_0_105", 8'h35);
    do_release();

    // Write and close together on the last bank
    start_load();
    close_bank();
    write(7, 8'h5A, 1);
    check("wc_state", 32'(state_dbg), S_READY);
    check("wc_done", 32'(done), 1);
    check("wc_rok", 32'(readin_ok), 0);
    read(CH - 1, 7, "rd_wc", 8'h5A);
    do_release();

    // Reset mid-LOAD
    start_load();
    for (int i = 0; i < 100; i++) write(i, $urandom_range(0, 255), 0);
    check("mid_fill", 32'(fill_count), 100);
    reset = 1;
    tick();
    reset = 0;
    check("abort_rok", 32'(readin_ok), 0);
    check("abort_done", 32'(done), 0);
    check("abort_ch", 32'(cur_ch), 0);
    check("abort_state", 32'(state_dbg), S_IDLE);
    tick();

    // Out-of-range bank, then read together with release
    start_load();
    close_bank();
    close_bank();
    read(3, 5, "rd_bad_ch", 0);
    set = 0;
    rd_en = 1; rd_ch = 2'd1; rd_index = 8'd7; release_req = 1;
    tick();
    rd_en = 0; release_req = 0;
    check("rr_valid", 32'(dout_valid), 1);
    check("rr_dout", 32'(dout), 8'h5A);
    tick();
    check("rr_valid_clear", 32'(dout_valid), 0);
    check("rr_done_clear", 32'(done), 0);

    // Randomised rounds checked by the model
    for (int r = 0; r < 4; r++) begin
      cyc = 0;
      set = 1;
      while (m_state != S_READY && cyc < 3000) begin
        set      = ($urandom_range(0, 9) != 0);
        readin   = 1'($urandom_range(0, 1));
        in_index = DP'($urandom_range(0, NENT - 1));
        din      = DW'($urandom_range(0, 255));
        full_in  = ($urandom_range(0, 39) == 0);
        rd_en    = 1'($urandom_range(0, 1));
        rd_ch    = 2'($urandom_range(0, 3));
        rd_index = DP'($urandom_range(0, NENT - 1));
        tick();
        cyc++;
      end
      clear_inputs();
      check("rand_reach_ready", 32'(state_dbg), S_READY);
      for (int k = 0; k < 40; k++) begin
        set      = 1'($urandom_range(0, 1));
        rd_en    = 1'($urandom_range(0, 3) != 0);
        rd_ch    = 2'($urandom_range(0, 3));
        rd_index = DP'($urandom_range(0, NENT - 1));
        tick();
      end
      rd_en = 1'($urandom_range(0, 1));
      do_release();
    end

    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
